vec_sequencer: RTL and testbench

Single-issue instruction sequencer for the 4-entry × 512-bit vector register file. It accepts one vector instruction at a time over a valid/ready handshake. It then drives the memory request handshake and the ALU start/done handshake, and issues the register-file read select and both write ports (select + enable). It sits between the instruction fetch stage and the register file, memory interface and vector ALU; it never touches 512-bit data itself.

---
 rtl/vec_pkg.sv | 25 ++
 rtl/vec_sequencer_if.sv | 41 ++++
 rtl/vec_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_vec_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector instruction sequencer: opcodes, FSM
// state encoding and the fixed vector register indices.
package vec_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned REG_W = 2;

  localparam logic [OP_W-1:0] OP_LOAD  = 2'b00;
  localparam logic [OP_W-1:0] OP_STORE = 2'b01;
  localparam logic [OP_W-1:0] OP_ADD   = 2'b10;
  localparam logic [OP_W-1:0] OP_MUL   = 2'b11;

  localparam logic [REG_W-1:0] REG_A1 = 2'd0;
  localparam logic [REG_W-1:0] REG_A2 = 2'd1;
  localparam logic [REG_W-1:0] REG_A3 = 2'd2;
  localparam logic [REG_W-1:0] REG_A4 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_ALU  = 2'd2,
    ST_WB   = 2'd3
  } vseq_state_e;

endpackage

// File: rtl/vec_sequencer_if.sv
// Handshake bundle between the sequencer and fetch / memory / ALU / register file.
// master = sequencer side, slave = surrounding datapath side.
interface vec_sequencer_if #(
  parameter int unsigned ADDR_W = 9
);

  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W+3:0] instr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              alu_start;
  logic              alu_op;
  logic              alu_done;
  logic [1:0]        read_sel;
  logic [1:0]        write_sel;
  logic              write_en;
  logic [1:0]        write_sel2;
  logic              write_en2;
  logic              wb_src;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  instr_valid, instr, mem_ack, alu_done,
    output instr_ready, mem_req, mem_we, mem_addr, alu_start, alu_op,
           read_sel, write_sel, write_en, write_sel2, write_en2, wb_src,
           busy, done, err
  );

  modport slave (
    output instr_valid, instr, mem_ack, alu_done,
    input  instr_ready, mem_req, mem_we, mem_addr, alu_start, alu_op,
           read_sel, write_sel, write_en, write_sel2, write_en2, wb_src,
           busy, done, err
  );

endinterface

// File: rtl/vec_sequencer.sv
// Single-issue sequencer for the 4 x 512-bit vector register file.
// Accepts one instruction, runs the memory or ALU handshake, then issues
// the register-file write. Optional watchdog: define VSEQ_TIMEOUT_EN.
module vec_sequencer
  import vec_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
`ifdef VSEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input logic       clk,
  input logic       reset,
  vec_sequencer_if.master bus
);

  vseq_state_e       state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [OP_W-1:0]   in_op_c;
  logic [REG_W-1:0]  in_reg_c;
  logic [ADDR_W-1:0] in_addr_c;
  logic              accept_c;
  logic              store_done_c;
  logic              timeout_c;

  logic              instr_ready_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic              alu_start_q;
  logic              alu_op_q;
  logic [REG_W-1:0]  read_sel_q;
  logic [REG_W-1:0]  write_sel_q;
  logic              write_en_q;
  logic [REG_W-1:0]  write_sel2_q;
  logic              write_en2_q;
  logic              wb_src_q;
  logic              busy_q;
  logic              done_q;

  assign in_op_c   = bus.instr[ADDR_W+3:ADDR_W+2];
  assign in_reg_c  = bus.instr[ADDR_W+1:ADDR_W];
  assign in_addr_c = bus.instr[ADDR_W-1:0];
  assign accept_c  = (state_q == ST_IDLE) && instr_ready_q && bus.instr_valid;

`ifdef VSEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_q, err_d;

  // Watchdog: counts cycles spent waiting in MEM or ALU, zero elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ST_MEM) || (state_q == ST_ALU)) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign timeout_c = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.err   = err_q;
`else
  assign timeout_c = 1'b0;
  assign bus.err   = 1'b0;
`endif

  // Next-state and instruction latch decode.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    reg_d        = reg_q;
    addr_d       = addr_q;
    store_done_c = 1'b0;
`ifdef VSEQ_TIMEOUT_EN
    err_d        = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          op_d    = in_op_c;
          reg_d   = in_reg_c;
          addr_d  = in_addr_c;
          state_d = in_op_c[1] ? ST_ALU : ST_MEM;
        end
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          store_done_c = (op_q == OP_STORE);
          state_d      = (op_q == OP_STORE) ? ST_IDLE : ST_WB;
        end else if (timeout_c) begin
          state_d = ST_IDLE;
`ifdef VSEQ_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      ST_ALU: begin
        if (bus.alu_done) begin
          state_d = ST_WB;
        end else if (timeout_c) begin
          state_d = ST_IDLE;
`ifdef VSEQ_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched instruction and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_LOAD;
      reg_q         <= REG_A1;
      addr_q        <= '0;
      instr_ready_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      alu_start_q   <= 1'b0;
      alu_op_q      <= 1'b0;
      read_sel_q    <= REG_A1;
      write_sel_q   <= REG_A1;
      write_en_q    <= 1'b0;
      write_sel2_q  <= REG_A1;
      write_en2_q   <= 1'b0;
      wb_src_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef VSEQ_TIMEOUT_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      reg_q         <= reg_d;
      addr_q        <= addr_d;
      instr_ready_q <= (state_d == ST_IDLE);
      busy_q        <= (state_d != ST_IDLE);
      mem_req_q     <= (state_d == ST_MEM);
      mem_we_q      <= (state_d == ST_MEM) && (op_d == OP_STORE);
      read_sel_q    <= (state_d == ST_MEM) ? reg_d : REG_A1;
      alu_start_q   <= (state_q != ST_ALU) && (state_d == ST_ALU);
      if (accept_c && in_op_c[1]) begin
        alu_op_q <= in_op_c[0];
      end
      write_en_q    <= (state_d == ST_WB);
      write_sel_q   <= (state_d != ST_WB)    ? REG_A1 :
                       (op_d == OP_LOAD)     ? reg_d  : REG_A3;
      wb_src_q      <= (state_d == ST_WB) && op_d[1];
      write_en2_q   <= (state_d == ST_WB) && (op_d == OP_MUL);
      write_sel2_q  <= ((state_d == ST_WB) && (op_d == OP_MUL)) ? REG_A4 : REG_A1;
      done_q        <= (state_d == ST_WB);
`ifdef VSEQ_TIMEOUT_EN
      err_q         <= err_d;
`endif
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.alu_start   = alu_start_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.read_sel    = read_sel_q;
  assign bus.write_sel   = write_sel_q;
  assign bus.write_en    = write_en_q;
  assign bus.write_sel2  = write_sel2_q;
  assign bus.write_en2   = write_en2_q;
  assign bus.wb_src      = wb_src_q;
  assign bus.busy        = busy_q;
  // STORE retires in its ack cycle; everything else retires in WB.
  assign bus.done        = done_q | (store_done_c & ~reset);

endmodule

// File: tb/tb_vec_sequencer.sv
// Self-checking bench for vec_sequencer. Each instruction is checked as a
// timeline: expected cycle offsets of request, write, done and ready are
// derived from the opcode and the handshake latency the bench chooses.
// Build with VSEQ_TIMEOUT_EN to include the watchdog scenario.
module tb_vec_sequencer;
  import vec_pkg::*;

  localparam int unsigned AW = 9;
`ifdef VSEQ_TIMEOUT_EN
  localparam int unsigned TO = 8;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic err_exp  = 1'b0;

  always #5 clk = ~clk;

  vec_sequencer_if #(.ADDR_W(AW)) bus ();

  vec_sequencer #(
    .ADDR_W(AW)
`ifdef VSEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one instruction and observe it until the sequencer is ready again.
  // lat: MEM/ALU cycle (1 = first) in which ack/done is given; 0 = never.
  // spur: drive the handshake input that does not belong to this opcode.
  task automatic run_instr(input logic [1:0] op, input logic [1:0] rg,
                           input logic [AW-1:0] addr, input int lat, input bit spur);
    int req_n = 0, wr_n = 0, wr2_n = 0, done_n = 0, start_n = 0, busy_n = 0, bad_mem = 0;
    int wr_c = -1, wr2_c = -1, done_c = -1, start_c = -1, rdy_c = -1;
    logic [1:0] wsel = 2'd0, wsel2 = 2'd0;
    logic wsrc = 1'b0, aop = 1'b0;
    bit is_alu = op[1];
    bit tmo = (lat == 0);
    int exp_rdy, exp_req, exp_wr, exp_done_c;

    bus.instr_valid = 1'b1;
    bus.instr       = {op, rg, addr};
    #1;
    check("ready_at_issue", 32'(bus.instr_ready), 32'd1);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 13'($urandom);
    for (int c = 1; c <= 40 && rdy_c < 0; c++) begin
      bus.mem_ack  = (!is_alu && c == lat) || (spur && is_alu && c == 2);
      bus.alu_done = (is_alu && c == lat) || (spur && !is_alu && c == 1);
      #1;
      if (bus.mem_req) begin
        req_n++;
        if (bus.mem_we !== (op == OP_STORE) || bus.mem_addr !== addr || bus.read_sel !== rg)
          bad_mem++;
      end
      if (bus.write_en)  begin wr_n++;  wr_c = c;  wsel = bus.write_sel; wsrc = bus.wb_src; end
      if (bus.write_en2) begin wr2_n++; wr2_c = c; wsel2 = bus.write_sel2; end
      if (bus.done)      begin done_n++; done_c = c; end
      if (bus.alu_start) begin start_n++; start_c = c; aop = bus.alu_op; end
      if (bus.busy) busy_n++;
      if (bus.instr_ready) rdy_c = c;
      @(posedge clk); #1;
    end
    bus.mem_ack  = 1'b0;
    bus.alu_done = 1'b0;

`ifdef VSEQ_TIMEOUT_EN
    if (tmo) begin
      exp_rdy = TO + 1; exp_wr = 0; exp_done_c = -1;
      err_exp = 1'b1;
    end else
`endif
    if (op == OP_STORE) begin
      exp_rdy = lat + 1; exp_wr = 0; exp_done_c = lat;
    end else begin
      exp_rdy = lat + 2; exp_wr = 1; exp_done_c = lat + 1;
    end
    exp_req = is_alu ? 0 : exp_rdy - 1 - ((op == OP_LOAD && !tmo) ? 1 : 0);

    check("ready_return_cycle", 32'(rdy_c), 32'(exp_rdy));
    check("busy_cycles", 32'(busy_n), 32'(exp_rdy - 1));
    check("mem_req_cycles", 32'(req_n), 32'(exp_req));
    check("mem_fields", 32'(bad_mem), 32'd0);
    check("write_en_pulses", 32'(wr_n), 32'(exp_wr));
    check("done_pulses", 32'(done_n), 32'(exp_done_c < 0 ? 0 : 1));
    check("done_cycle", 32'(done_c), 32'(exp_done_c));
    check("alu_start_pulses", 32'(start_n), 32'(is_alu ? 1 : 0));
    if (is_alu) begin
      check("alu_start_cycle", 32'(start_c), 32'd1);
      check("alu_op", 32'(aop), 32'(op[0]));
    end
    if (exp_wr == 1) begin
      check("write_cycle", 32'(wr_c), 32'(lat + 1));
      check("write_sel", 32'(wsel), 32'(is_alu ? REG_A3 : rg));
      check("wb_src", 32'(wsrc), 32'(is_alu));
    end
    check("write_en2_pulses", 32'(wr2_n), 32'((op == OP_MUL && !tmo) ? 1 : 0));
    if (op == OP_MUL && !tmo) begin
      check("write2_cycle", 32'(wr2_c), 32'(wr_c));
      check("write_sel2", 32'(wsel2), 32'(REG_A4));
    end
    check("err", 32'(bus.err), 32'(err_exp));
  endtask

  // ADD held valid continuously: accepts must be exactly 3 cycles apart.
  task automatic back_to_back();
    int acc[$];
    int mreq = 0, wr = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = {OP_ADD, 2'd0, 9'h055};
    for (int c = 0; c < 12; c++) begin
      bus.alu_done = bus.alu_start;
      bus.mem_ack  = 1'b1;
      #1;
      if (bus.instr_valid && bus.instr_ready) acc.push_back(c);
      if (bus.mem_req)  mreq++;
      if (bus.write_en) wr++;
      @(posedge clk); #1;
    end
    bus.instr_valid = 1'b0;
    bus.alu_done    = 1'b0;
    bus.mem_ack     = 1'b0;
    check("b2b_accepts", 32'(acc.size()), 32'd4);
    if (acc.size() >= 3) begin
      check("b2b_gap1", 32'(acc[1] - acc[0]), 32'd3);
      check("b2b_gap2", 32'(acc[2] - acc[1]), 32'd3);
    end
    check("b2b_spurious_mem", 32'(mreq), 32'd0);
    check("b2b_writes", 32'(wr), 32'(acc.size()));
    check("b2b_idle_ready", 32'(bus.instr_ready), 32'd1);
  endtask

  // Reset while a LOAD waits in MEM; a late ack must not produce a write.
  task automatic reset_mid_mem();
    int wr = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = {OP_LOAD, 2'd3, 9'h0AA};
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    check("rst_mid_req", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #1;
    reset       = 1'b1;
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_req_off", 32'(bus.mem_req), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    check("rst_mid_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mid_rsel", 32'(bus.read_sel), 32'd0);
    check("rst_mid_ready", 32'(bus.instr_ready), 32'd0);
    reset       = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.write_en) wr++;
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0;
    err_exp     = 1'b0;
    check("rst_mid_no_write", 32'(wr), 32'd0);
    check("rst_mid_ready_back", 32'(bus.instr_ready), 32'd1);
  endtask

  initial begin
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.mem_ack     = 1'b0;
    bus.alu_done    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_write_en", 32'(bus.write_en), 32'd0);
    check("rst_alu_start", 32'(bus.alu_start), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(bus.instr_ready), 32'd1);

    run_instr(OP_LOAD,  2'd1, 9'h005, 3, 1'b0);
    run_instr(OP_STORE, 2'd2, 9'h1FF, 2, 1'b0);
    run_instr(OP_MUL,   2'd0, 9'h010, 5, 1'b0);
    run_instr(OP_ADD,   2'd3, 9'h020, 3, 1'b1);
    run_instr(OP_LOAD,  2'd3, 9'h000, 1, 1'b1);
    run_instr(OP_STORE, 2'd0, 9'h100, 1, 1'b0);
    run_instr(OP_ADD,   2'd1, 9'h0F0, 1, 1'b0);
    run_instr(OP_MUL,   2'd2, 9'h0F0, 1, 1'b0);
    back_to_back();
    reset_mid_mem();
    run_instr(OP_LOAD,  2'd2, 9'h033, 2, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_instr(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), AW'($urandom),
                int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
    end

`ifdef VSEQ_TIMEOUT_EN
    run_instr(OP_LOAD, 2'd1, 9'h005, 0, 1'b0);
    run_instr(OP_ADD,  2'd0, 9'h000, 2, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
